// File: rtl/fifo_pkg.sv
// Shared types for the FIFO: per-cycle handshake operation and its decoder.
package fifo_pkg;

  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPush = 2'b01,
    OpPop  = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_decode_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides and any DEPTH >= 2.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign s_tready = ~full;
  assign m_tvalid = ~empty;

  // Accept/complete decisions depend only on registered occupancy, never on the other side.
  assign push = s_tvalid & ~full & ~resetn;
  assign pop  = m_tready & ~empty & ~resetn;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case (fifo_decode_op(push, pop))
      OpPush:  count_d = count_q + 1'b1;
      OpPop:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AddrW (PtrW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_tdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (m_tdata)
  );

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: queue reference model, per-cycle compare, directed and random stimulus.
module tb_fifo;

  localparam int unsigned DEPTH = 10;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic             s_tvalid;
  logic             s_tready;
  logic [WIDTH-1:0] s_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic [WIDTH-1:0] m_tdata;
  logic             full;
  logic             empty;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  bit               model_live = 1'b0;
  bit               last_push  = 1'b0;

  always #5 clk = ~clk;

  fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .full     (full),
    .empty    (empty)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words; acceptance decided from the queue size before the edge.
  always @(posedge clk) begin
    bit push, pop;
    push = !resetn && s_tvalid && (q.size() < DEPTH);
    pop  = !resetn && m_tready && (q.size() > 0);
    if (resetn) begin
      q.delete();
      model_live = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(s_tdata);
    end
    last_push = push;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("s_tready", int'(s_tready), int'(q.size() != DEPTH));
      chk("m_tvalid", int'(m_tvalid), int'(q.size() != 0));
      if (q.size() > 0) chk("m_tdata_head", int'(m_tdata), int'(q[0]));
    end
  end

  initial begin
    logic [WIDTH-1:0] wdata;
    resetn   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_s_tready", int'(s_tready), 1);
    chk("reset_m_tvalid", int'(m_tvalid), 0);
    resetn = 1'b0;

    // Fill 0..9 with the read side stalled, then offer an 11th word.
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(i);
      @(negedge clk);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_s_tready", int'(s_tready), 0);
    s_tdata = 8'hEE;
    @(negedge clk);
    chk("fill_no_overflow_full", int'(full), 1);
    chk("fill_model_size", q.size(), 10);
    s_tvalid = 1'b0;

    // Drain: head must walk 0..9.
    m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("drain_m_tvalid", int'(m_tvalid), 1);
      chk("drain_data", int'(m_tdata), i);
      @(negedge clk);
    end
    chk("drain_empty", int'(empty), 1);
    m_tready = 1'b0;

    // First-word-fall-through.
    s_tvalid = 1'b1;
    s_tdata  = 8'h5A;
    @(negedge clk);
    s_tvalid = 1'b0;
    chk("fwft_m_tvalid", int'(m_tvalid), 1);
    chk("fwft_data", int'(m_tdata), 8'h5A);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;

    // Pointers now at 1; fill 8 and read 3 so the write pointer sits at 9 with count 5.
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(8'h10 + i);
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("sim_pre_size", q.size(), 5);
    for (int i = 0; i < 6; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(8'h20 + i);
      chk("sim_data", int'(m_tdata), (i < 5) ? (8'h13 + i) : 8'h20);
      @(negedge clk);
      chk("sim_not_full", int'(full), 0);
      chk("sim_not_empty", int'(empty), 0);
    end
    chk("sim_post_size", q.size(), 5);
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("wrap_data", int'(m_tdata), 8'h21 + i);
      @(negedge clk);
    end
    chk("wrap_empty", int'(empty), 1);
    m_tready = 1'b0;

    // Reset mid-operation with a handshake offered in the reset cycle.
    s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = 8'(8'h40 + i);
      @(negedge clk);
    end
    resetn   = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    resetn   = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    chk("midreset_empty", int'(empty), 1);
    chk("midreset_m_tvalid", int'(m_tvalid), 0);

    // Random stress with an incrementing data stream.
    wdata = '0;
    for (int c = 0; c < 10000; c++) begin
      s_tvalid = 1'($urandom_range(0, 1));
      m_tready = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata  = wdata;
      @(negedge clk);
      if (last_push) wdata = wdata + 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
